// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: state encoding,
// common constants and a small width helper.
package pc_gen_pkg;

  typedef enum logic {
    PCG_WARM = 1'b0,
    PCG_RUN  = 1'b1
  } pcg_state_e;

  localparam logic [31:0] ZeroWord           = 32'h0;
  localparam logic        True               = 1'b1;
  localparam logic        False              = 1'b0;
  localparam int          INST_BYTES_DEFAULT = 4;

  // Index width for an N-way selection; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/redir_arb.sv
// Fixed-priority arbiter for redirect requests: the lowest set index wins,
// producing a one-hot grant, the binary index of the winner and an any flag.
module redir_arb
  import pc_gen_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest requesting index is the last writer.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = False;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = True;
        idx      = IDX_W'(i);
        any      = True;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with warm-up, prioritised redirects
// and an epoch tag. Define PC_GEN_PRED_EN to take the next PC from prd_pc.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter int              NUM_REDIR   = 2,
  parameter int              START_DELAY = 1,
  parameter int              EPOCH_W     = 3,
  parameter int              INST_BYTES  = INST_BYTES_DEFAULT,
  localparam int             SRC_W       = idx_width(NUM_REDIR)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
`ifdef PC_GEN_PRED_EN
  input  logic [XLEN-1:0]           prd_pc,
`endif
  input  logic                      pc_ready,
  output logic [XLEN-1:0]           pc_o,
  output logic                      pc_valid,
  output logic [EPOCH_W-1:0]        pc_epoch,
  output logic                      redir_taken,
  output logic [SRC_W-1:0]          redir_src
);

  localparam int              CNT_W      = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [XLEN-1:0] LOW_MASK   = XLEN'(INST_BYTES - 1);
  localparam pcg_state_e      INIT_STATE = (START_DELAY == 0) ? PCG_RUN : PCG_WARM;

  pcg_state_e           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [XLEN-1:0]      pc_nxt, next_pc, target;
  logic [EPOCH_W-1:0]   epoch_nxt;
  logic                 taken_nxt;
  logic [SRC_W-1:0]     src_nxt;
  logic [NUM_REDIR-1:0] grant;
  logic [SRC_W-1:0]     grant_idx;
  logic                 grant_any;

  redir_arb #(
    .N     (NUM_REDIR),
    .IDX_W (SRC_W)
  ) u_arb (
    .req   (redir_valid),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Redirect targets are forced onto an instruction boundary.
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_REDIR; i++) begin
      if (grant[i]) target = redir_pc[i*XLEN +: XLEN];
    end
    target = target & ~LOW_MASK;
  end

`ifdef PC_GEN_PRED_EN
  assign next_pc = prd_pc & ~LOW_MASK;
`else
  assign next_pc = pc_o + XLEN'(INST_BYTES);
`endif

  assign pc_valid = (state == PCG_RUN) && rdy;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc_o;
    epoch_nxt = pc_epoch;
    taken_nxt = False;
    src_nxt   = redir_src;
    if (!rdy) begin
      state_nxt = INIT_STATE;
      cnt_nxt   = CNT_W'(START_DELAY);
    end else begin
      if (state == PCG_WARM) begin
        if (cnt <= CNT_W'(1)) state_nxt = PCG_RUN;
        else                  cnt_nxt   = cnt - 1'b1;
      end
      // A redirect wins over sequential advance and does not need pc_ready.
      if (grant_any) begin
        pc_nxt    = target;
        epoch_nxt = pc_epoch + 1'b1;
        taken_nxt = True;
        src_nxt   = grant_idx;
      end else if (state == PCG_RUN && pc_ready) begin
        pc_nxt = next_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT_STATE;
      cnt         <= CNT_W'(START_DELAY);
      pc_o        <= RESET_VEC;
      pc_epoch    <= '0;
      redir_taken <= False;
      redir_src   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pc_o        <= pc_nxt;
      pc_epoch    <= epoch_nxt;
      redir_taken <= taken_nxt;
      redir_src   <= src_nxt;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues the expected outputs of each
// cycle, a separate monitor pops and compares them mid-cycle.
module tb_pc_gen;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [2:0]  epoch;
    logic        taken;
    logic        src;
  } exp_t;

`ifdef PC_GEN_PRED_EN
  localparam logic [31:0] WRAP_PC = 32'h40;
`else
  localparam logic [31:0] WRAP_PC = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic [1:0]  redir_valid = '0;
  logic [63:0] redir_pc = '0;
  logic        pc_ready = 1'b1;
  logic [31:0] pc_o;
  logic        pc_valid;
  logic [2:0]  pc_epoch;
  logic        redir_taken;
  logic        redir_src;
`ifdef PC_GEN_PRED_EN
  logic [31:0] prd_pc = '0;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
`ifdef PC_GEN_PRED_EN
    .prd_pc      (prd_pc),
`endif
    .pc_ready    (pc_ready),
    .pc_o        (pc_o),
    .pc_valid    (pc_valid),
    .pc_epoch    (pc_epoch),
    .redir_taken (redir_taken),
    .redir_src   (redir_src)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_output(input exp_t e);
    compare("pc_o", pc_o, e.pc);
    compare("pc_valid", 32'(pc_valid), 32'(e.valid));
    compare("pc_epoch", 32'(pc_epoch), 32'(e.epoch));
    compare("redir_taken", 32'(redir_taken), 32'(e.taken));
    if (e.taken) compare("redir_src", 32'(redir_src), 32'(e.src));
  endtask

  // Drive one cycle of inputs and queue what the outputs must show this cycle.
  task automatic apply_stimulus(input logic r, input logic rd, input logic prdy,
                                input logic [1:0] rv, input logic [31:0] rp0, input logic [31:0] rp1,
                                input logic [31:0] e_pc, input logic e_valid, input logic [2:0] e_epoch,
                                input logic e_taken, input logic e_src);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    rdy         = rd;
    pc_ready    = prdy;
    redir_valid = rv;
    redir_pc    = {rp1, rp0};
`ifdef PC_GEN_PRED_EN
    prd_pc      = (e_pc == 32'hFFFF_FFFC) ? 32'h40 : e_pc + 32'd4;
`endif
    e.pc    = e_pc;
    e.valid = e_valid;
    e.epoch = e_epoch;
    e.taken = e_taken;
    e.src   = e_src;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : driver
    int wait_cycles;
    // Reset, then one warm-up cycle before sequential fetch.
    apply_stimulus(1, 1, 1, 2'b00, 0, 0, 32'h0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h4, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h8, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'hC, 1, 0, 0, 0);
    // Stall for three cycles, then resume.
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h10, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h10, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h10, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h10, 1, 0, 0, 0);
    // Both channels request: channel 0 wins.
    apply_stimulus(0, 1, 1, 2'b11, 32'h100, 32'h200, 32'h14, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h100, 1, 1, 1, 0);
    apply_stimulus(0, 1, 1, 2'b10, 0, 32'h200, 32'h100, 1, 1, 0, 0);
    // Back-to-back misaligned redirects walk the epoch through its wrap.
    apply_stimulus(0, 1, 1, 2'b01, 32'h103, 0, 32'h200, 1, 2, 1, 1);
    for (int k = 0; k < 5; k++)
      apply_stimulus(0, 1, 1, 2'b01, 32'h103, 0, 32'h100, 1, 3'(3 + k), 1, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h100, 1, 0, 1, 0);
    // Loss of rdy freezes everything and ignores redirects, then warm-up again.
    apply_stimulus(0, 0, 1, 2'b01, 32'h300, 0, 32'h100, 0, 0, 0, 0);
    apply_stimulus(0, 0, 1, 2'b01, 32'h300, 0, 32'h100, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h100, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h100, 1, 0, 0, 0);
    // Jump to the top of the address space and advance across the wrap.
    apply_stimulus(0, 1, 1, 2'b01, 32'hFFFF_FFFC, 0, 32'h104, 1, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'hFFFF_FFFC, 1, 1, 1, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, WRAP_PC, 1, 1, 0, 0);
    // Reset asserted together with a redirect request.
    apply_stimulus(1, 1, 1, 2'b01, 32'h500, 0, WRAP_PC, 1, 1, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 2'b00, 0, 0, 32'h0, 1, 0, 0, 0);
    apply_stimulus(0, 1, 0, 2'b00, 0, 0, 32'h4, 1, 0, 0, 0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
